// File: rtl/pipe_mdu_ctl_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Contents: MDU operation encodings, FSM state encoding, iteration count,
// and a helper that classifies signed operations.
package pipe_defs;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam int MD_STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_t;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/pipe_mdu_ctl_step.sv
// mdu_step: one radix-2 iteration of the multiply/divide loop (combinational).
// Ports:
//   acc     - current accumulator; multiply {upper, multiplier}, divide {rem, quot}
//   opnd    - multiplicand (multiply) or divisor (divide), unsigned magnitude
//   is_div  - 1 selects shift-subtract, 0 selects shift-add
//   acc_nxt - accumulator after this iteration
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             rem_ge;

    always_comb begin
        // multiply: the carry out of the add becomes the new msb after the shift
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // divide: remainder shifted left with the next dividend bit, WIDTH+1 bits wide
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        rem_ge = rem_sh >= {1'b0, opnd};
        // when rem_ge holds the true difference is below opnd, so WIDTH bits suffice
        diff   = rem_sh[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (rem_ge) acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
            else        acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/pipe_mdu_ctl.sv
// pipe_mdu_ctl: iterative MULT/MULTU/DIV/DIVU sequencer with private HI/LO.
//
//   state | meaning
//   IDLE  | waiting for Start; operands latched on accept
//   CALC  | one radix-2 iteration per cycle, MD_STEPS cycles
//   FIX   | sign correction and HI/LO write (one cycle)
//
// Ports:
//   Clk, Clrn    - clock, asynchronous active-high reset
//   Start, Md_op - ID stage MDU op valid and its encoding
//   A, B         - rs / rt operands
//   Mf_req       - ID stage holds MFHI/MFLO
//   Flush        - abort the op in flight
//   Busy, Stall  - not idle; freeze IF/ID for a dependent MDU instruction
//   Done         - one-cycle pulse when new HI/LO become visible
//   Div0         - sticky divide-by-zero flag
//   Hi, Lo       - result registers
module pipe_mdu_ctl
    import pipe_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             Start,
    input  logic [1:0]       Md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Mf_req,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             Div0,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(MD_STEPS);

    mdu_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, acc_step, fix_val;
    logic [WIDTH-1:0]   opnd, a_abs, b_abs;
    logic [1:0]         op_q;
    logic               neg_q, neg_r, div0_mk;
    logic               accept, sgn_in, div0_in, last_step, fix_wr;

    assign accept    = (state == ST_IDLE) && Start && !Flush;
    assign sgn_in    = is_signed_op(Md_op);
    assign div0_in   = Md_op[1] && (B == '0);
    assign last_step = (cnt == CNT_W'(MD_STEPS - 1));
    assign fix_wr    = (state == ST_FIX) && !Flush;
    assign a_abs     = (sgn_in && A[WIDTH-1]) ? -A : A;
    assign b_abs     = (sgn_in && B[WIDTH-1]) ? -B : B;

    always_ff @(posedge Clk or posedge Clrn) begin
        if (Clrn) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = div0_in ? ST_FIX : ST_CALC;
            ST_CALC: begin
                if (Flush)          state_nxt = ST_IDLE;
                else if (last_step) state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state != ST_IDLE);
    end

    assign Stall = Busy && (Start || Mf_req);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .opnd    (opnd),
        .is_div  (op_q[1]),
        .acc_nxt (acc_step)
    );

    always_ff @(posedge Clk or posedge Clrn) begin
        if (Clrn) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0_mk <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            op_q    <= Md_op;
            neg_q   <= sgn_in && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r   <= sgn_in && A[WIDTH-1];
            div0_mk <= div0_in;
            // div-by-zero preloads the final HI/LO image so FIX just copies it
            if (div0_in) begin
                acc  <= {A, {WIDTH{1'b1}}};
                opnd <= '0;
            end else if (Md_op[1]) begin
                acc  <= {{WIDTH{1'b0}}, a_abs};
                opnd <= b_abs;
            end else begin
                acc  <= {{WIDTH{1'b0}}, b_abs};
                opnd <= a_abs;
            end
        end else if ((state == ST_CALC) && !Flush) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        fix_val = acc;
        if (!div0_mk) begin
            if (op_q[1]) begin
                if (neg_q) fix_val[WIDTH-1:0]       = -acc[WIDTH-1:0];
                if (neg_r) fix_val[2*WIDTH-1:WIDTH] = -acc[2*WIDTH-1:WIDTH];
            end else if (neg_q) begin
                fix_val = -acc;
            end
        end
    end

    always_ff @(posedge Clk or posedge Clrn) begin
        if (Clrn) begin
            Hi   <= '0;
            Lo   <= '0;
            Done <= 1'b0;
            Div0 <= 1'b0;
        end else begin
            Done <= fix_wr;
            if (fix_wr) begin
                Hi <= fix_val[2*WIDTH-1:WIDTH];
                Lo <= fix_val[WIDTH-1:0];
            end
            if (accept)                Div0 <= 1'b0;
            else if (fix_wr && div0_mk) Div0 <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_mdu_ctl.sv
module tb_pipe_mdu_ctl;
    import pipe_defs::*;

    logic        clk = 1'b0;
    logic        rst, start, mf_req, flush;
    logic [1:0]  md_op;
    logic [31:0] a, b;
    logic        busy, stall, done, div0;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_mis = 0;
    int last_stall_n;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    logic [31:0] h_prev, l_prev, ra, rb, eh, el;
    logic [1:0]  rop;
    logic        ed;
    int          sel, seen, rlat;

    always #5 clk = ~clk;

    pipe_mdu_ctl #(.WIDTH(32)) dut (
        .Clk    (clk),
        .Clrn   (rst),
        .Start  (start),
        .Md_op  (md_op),
        .A      (a),
        .B      (b),
        .Mf_req (mf_req),
        .Flush  (flush),
        .Busy   (busy),
        .Stall  (stall),
        .Done   (done),
        .Div0   (div0),
        .Hi     (hi),
        .Lo     (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: plain integer arithmetic on the architectural operands
    function automatic void model(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] mh, output logic [31:0] ml, output logic md0);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(av);
        sb = $signed(bv);
        mh = '0; ml = '0; md0 = 1'b0;
        if (op[1] && bv == 0) begin
            mh = av; ml = 32'hFFFF_FFFF; md0 = 1'b1;
        end else if (op == MD_MULTU) begin
            p = {32'h0, av} * {32'h0, bv};
            mh = p[63:32]; ml = p[31:0];
        end else if (op == MD_MULT) begin
            p = sa * sb;
            mh = p[63:32]; ml = p[31:0];
        end else if (op == MD_DIVU) begin
            ml = av / bv; mh = av % bv;
        end else begin
            q = sa / sb; r = sa % sb;
            ml = q[31:0]; mh = r[31:0];
        end
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; md_op = op; a = av; b = bv;
    endtask

    // Called just before the accepting edge E0; returns #1 after the Done edge.
    task automatic finish_op(input string tag, input int exp_lat);
        int          n, busy_n, stall_n;
        logic [31:0] h0, l0;
        logic        hold_ok, d0_first;
        h0 = hi; l0 = lo; hold_ok = 1'b1;
        n = 0; busy_n = 0; stall_n = 0;
        @(posedge clk); #1;
        start = 1'b0;
        d0_first = div0;
        while (!done && n < 60) begin
            if (busy)  busy_n++;
            if (stall) stall_n++;
            if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        last_stall_n = stall_n;
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_lat));
        chk({tag, " div0_clear_on_start"}, 64'(d0_first), 64'd0);
        chk({tag, " hilo_hold"}, 64'(hold_ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[3] = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
        vecs[4] = '{MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
        vecs[5] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
        vecs[6] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[7] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[8] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1};

        rst = 1'b1; start = 1'b0; mf_req = 1'b0; flush = 1'b0;
        md_op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset div0", 64'(div0), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            finish_op($sformatf("vec%0d", i), vecs[i].lat);
            chk($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
            chk($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
            chk($sformatf("vec%0d div0", i), 64'(div0), 64'(vecs[i].d0));
            @(posedge clk); #1;
            chk($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
            chk($sformatf("vec%0d idle", i), 64'(busy), 64'd0);
        end

        // Mf_req held through a multiply stalls every busy cycle
        @(negedge clk);
        mf_req = 1'b1;
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        finish_op("mfstall", 33);
        chk("mfstall stall_cycles", 64'(last_stall_n), 64'd33);
        chk("mfstall stall_after_done", 64'(stall), 64'd0);
        chk("mfstall hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mfstall lo", 64'(lo), 64'hFFFF_FFEB);
        mf_req = 1'b0;

        // Flush at CALC step 10
        h_prev = hi; l_prev = lo;
        @(negedge clk);
        issue(MD_MULT, 32'd1234, 32'd5678);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        chk("flush no_done", 64'(seen), 64'd0);
        chk("flush hi", 64'(hi), 64'(h_prev));
        chk("flush lo", 64'(lo), 64'(l_prev));

        // Flush in FIX (div-by-zero path) suppresses the write
        @(negedge clk);
        issue(MD_DIVU, 32'd9, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flushfix busy", 64'(busy), 64'd0);
        chk("flushfix done", 64'(done), 64'd0);
        chk("flushfix hi", 64'(hi), 64'(h_prev));

        // Flush overrides Start in IDLE
        @(negedge clk);
        issue(MD_MULTU, 32'd3, 32'd3);
        flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flushidle busy", 64'(busy), 64'd0);

        // Back-to-back: second Start presented in the Done cycle
        @(negedge clk);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("b2b_first", 33);
        chk("b2b_first hi", 64'(hi), 64'hFFFF_FFFE);
        chk("b2b_first lo", 64'(lo), 64'h0000_0001);
        issue(MD_DIVU, 32'd100, 32'd7);
        finish_op("b2b_second", 33);
        chk("b2b_second hi", 64'(hi), 64'd2);
        chk("b2b_second lo", 64'(lo), 64'd14);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        issue(MD_MULT, 32'd77, 32'd99);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst hi", 64'(hi), 64'd0);
        chk("midrst lo", 64'(lo), 64'd0);
        chk("midrst div0", 64'(div0), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            model(rop, ra, rb, eh, el, ed);
            rlat = (rop[1] && rb == 0) ? 1 : 33;
            @(negedge clk);
            issue(rop, ra, rb);
            finish_op($sformatf("rnd%0d", i), rlat);
            chk($sformatf("rnd%0d hi op%0d %h %h", i, rop, ra, rb), 64'(hi), 64'(eh));
            chk($sformatf("rnd%0d lo op%0d %h %h", i, rop, ra, rb), 64'(lo), 64'(el));
            chk($sformatf("rnd%0d div0", i), 64'(div0), 64'(ed));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
